// File: rtl/nn_pkg.sv
// Shared constants and FSM state encoding for the neuron argmax block.
package nn_pkg;

  localparam int NEURON_W  = 8;
  localparam int N_NEURONS = 4;
  localparam int IDX_W     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Unsigned full-width compare of a snapshot entry against the running maximum.
module argmax_cmp #(
  parameter int W = nn_pkg::NEURON_W
) (
  input  logic [W-1:0] entry,
  input  logic [W-1:0] run_max,
  output logic         greater,
  output logic         equal
);

  assign greater = entry > run_max;
  assign equal   = entry == run_max;

endmodule

// File: rtl/neuron_argmax.sv
// Sequential argmax over four captured neuron outputs, one entry per cycle.
// Tie detection is built only when ARGMAX_TIE_EN is defined; otherwise tie is 0.
module neuron_argmax #(
  parameter int DATA_W    = nn_pkg::NEURON_W,
  parameter int N_NEURONS = nn_pkg::N_NEURONS
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [DATA_W-1:0]            neuron0_output,
  input  logic [DATA_W-1:0]            neuron1_output,
  input  logic [DATA_W-1:0]            neuron2_output,
  input  logic [DATA_W-1:0]            neuron3_output,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(N_NEURONS)-1:0] class_idx,
  output logic [DATA_W-1:0]            max_val,
  output logic                         tie,
  output nn_pkg::state_t               state_dbg
);
  import nn_pkg::*;

  localparam int SEL_W = $clog2(N_NEURONS);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_NEURONS - 1);

  // Handshake: start is sampled only while busy=0; a sampled start launches
  // one scan and done pulses for exactly one cycle when the result updates.

  state_t              state_q, state_n;
  logic [DATA_W-1:0]   snap [N_NEURONS];
  logic [SEL_W-1:0]    scan_idx;
  logic [DATA_W-1:0]   run_max, run_max_n;
  logic [SEL_W-1:0]    run_idx, run_idx_n;
  logic [DATA_W-1:0]   entry;
  logic                greater;
  logic                equal;

  assign entry = snap[scan_idx];

  argmax_cmp #(.W(DATA_W)) u_cmp (
    .entry   (entry),
    .run_max (run_max),
    .greater (greater),
    .equal   (equal)
  );

`ifdef ARGMAX_TIE_EN
  logic run_tie, run_tie_n;
`else
  logic unused_equal;
  assign unused_equal = equal;
  assign tie = 1'b0;
`endif

  // Strict greater-than means equal entries never displace the lower index.
  always_comb begin
    run_max_n = run_max;
    run_idx_n = run_idx;
`ifdef ARGMAX_TIE_EN
    run_tie_n = run_tie;
`endif
    if (scan_idx == '0) begin
      run_max_n = entry;
      run_idx_n = '0;
`ifdef ARGMAX_TIE_EN
      run_tie_n = 1'b0;
`endif
    end else if (greater) begin
      run_max_n = entry;
      run_idx_n = scan_idx;
`ifdef ARGMAX_TIE_EN
      run_tie_n = 1'b0;
    end else if (equal) begin
      run_tie_n = 1'b1;
`endif
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (start) state_n = SCAN;
      SCAN:    if (scan_idx == LAST_IDX) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_NEURONS; i++) snap[i] <= '0;
      scan_idx  <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      class_idx <= '0;
      max_val   <= '0;
`ifdef ARGMAX_TIE_EN
      run_tie   <= 1'b0;
      tie       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            snap[0]  <= neuron0_output;
            snap[1]  <= neuron1_output;
            snap[2]  <= neuron2_output;
            snap[3]  <= neuron3_output;
            scan_idx <= '0;
          end
        end
        SCAN: begin
          run_max  <= run_max_n;
          run_idx  <= run_idx_n;
          scan_idx <= scan_idx + SEL_W'(1);
`ifdef ARGMAX_TIE_EN
          run_tie  <= run_tie_n;
`endif
          // Publish on the edge that folds in the last entry.
          if (scan_idx == LAST_IDX) begin
            class_idx <= run_idx_n;
            max_val   <= run_max_n;
`ifdef ARGMAX_TIE_EN
            tie       <= run_tie_n;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_neuron_argmax.sv
// Directed bench for neuron_argmax with a result scoreboard checked on every done pulse.
module tb_neuron_argmax;
  import nn_pkg::*;

  localparam int RW = 11;
`ifdef ARGMAX_TIE_EN
  localparam bit TIE_EN = 1'b1;
`else
  localparam bit TIE_EN = 1'b0;
`endif

  logic       clk;
  logic       rstn;
  logic       start;
  logic [7:0] n0, n1, n2, n3;
  logic       busy, done, tie;
  logic [1:0] class_idx;
  logic [7:0] max_val;
  state_t     state_dbg;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_e;

  neuron_argmax dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .neuron0_output (n0),
    .neuron1_output (n1),
    .neuron2_output (n2),
    .neuron3_output (n3),
    .busy           (busy),
    .done           (done),
    .class_idx      (class_idx),
    .max_val        (max_val),
    .tie            (tie),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: first index of the maximum, tie when the maximum occurs twice or more.
  function automatic logic [RW-1:0] model(input logic [7:0] a, b, c, d);
    logic [7:0] v[4];
    logic [7:0] m;
    logic [1:0] idx;
    int cnt;
    v = '{a, b, c, d};
    m = 8'd0;
    for (int i = 0; i < 4; i++) if (v[i] > m) m = v[i];
    idx = 2'd0;
    cnt = 0;
    for (int i = 3; i >= 0; i--) if (v[i] == m) begin idx = 2'(i); cnt++; end
    return {idx, m, TIE_EN && (cnt > 1)};
  endfunction

  // driver tasks
  task automatic drive_inputs(input logic [7:0] a, b, c, d);
    n0 = a; n1 = b; n2 = c; n3 = d;
  endtask

  task automatic pulse_start(input logic [7:0] a, b, c, d, input bit accept);
    drive_inputs(a, b, c, d);
    start = 1'b1;
    if (accept) exp_q.push_back(model(a, b, c, d));
    @(negedge clk);
    start = 1'b0;
  endtask

  // n0 = negedges already elapsed since the start edge.
  task automatic wait_done(input string tag, input int n0_cycles);
    int n;
    int busy_n;
    n = n0_cycles;
    busy_n = (busy === 1'b1) ? n0_cycles : 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) busy_n++;
    end
    chk({tag, "_latency"}, n, 5);
    chk({tag, "_busy_cycles"}, busy_n, 5);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 1'b0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("class_idx", class_idx, mon_e[10:9]);
        chk("max_val", max_val, mon_e[8:1]);
        chk("tie", tie, mon_e[0]);
      end else begin
        chk("spurious_done", done, 1'b0);
      end
    end
  end

  initial begin
    int d0;
    int pos[$];
    rstn = 1'b0;
    start = 1'b0;
    drive_inputs(8'd0, 8'd0, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_class_idx", class_idx, 2'd0);
    chk("rst_max_val", max_val, 8'd0);
    chk("rst_tie", tie, 1'b0);
    chk("rst_state", state_dbg, IDLE);

    // first start right at release
    rstn = 1'b1;
    pulse_start(8'd10, 8'd200, 8'd50, 8'd3, 1'b1);
    chk("t1_busy_first", busy, 1'b1);
    wait_done("t1", 1);
    repeat (3) @(negedge clk);
    chk("t1_hold_max", max_val, 8'd200);
    chk("t1_hold_idx", class_idx, 2'd1);

    // equal maxima
    pulse_start(8'd90, 8'd90, 8'd20, 8'd90, 1'b1);
    wait_done("t2", 1);

    // input change after capture plus ignored start during SCAN
    d0 = done_cnt;
    pulse_start(8'd0, 8'd0, 8'd0, 8'd255, 1'b1);
    drive_inputs(8'd255, 8'd0, 8'd0, 8'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t3", 3);
    repeat (8) @(negedge clk);
    chk("t3_done_count", done_cnt - d0, 1);
    chk("t3_idle", busy, 1'b0);

    // reset in the second SCAN cycle
    pulse_start(8'd7, 8'd8, 8'd9, 8'd6, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("t4_busy", busy, 1'b0);
    chk("t4_done", done, 1'b0);
    chk("t4_class_idx", class_idx, 2'd0);
    chk("t4_max_val", max_val, 8'd0);
    chk("t4_tie", tie, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_busy_after", busy, 1'b0);

    // start held high for 18 cycles
    d0 = done_cnt;
    drive_inputs(8'd1, 8'd2, 8'd3, 8'd4);
    for (int i = 0; i < 3; i++) exp_q.push_back(model(8'd1, 8'd2, 8'd3, 8'd4));
    start = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (done === 1'b1) pos.push_back(i);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("t5_done_count", done_cnt - d0, 3);
    chk("t5_pos_count", pos.size(), 3);
    if (pos.size() == 3) begin
      chk("t5_first", pos[0], 5);
      chk("t5_gap1", pos[1] - pos[0], 6);
      chk("t5_gap2", pos[2] - pos[1], 6);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
